// File: rtl/alarm_pkg.sv
// Shared types and constants for the anti-theft alarm sequencer: state
// encodings, delay-table indices, time type and table defaults.
package alarm_pkg;

    typedef logic [3:0] time_t;

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        WAIT_CLOSE  = 3'd1,
        ARM_DELAY   = 3'd2,
        ARMED       = 3'd3,
        TRIGGERED   = 3'd4,
        SOUND_ALARM = 3'd5,
        ALARM_HOLD  = 3'd6
    } state_t;

    localparam int NUM_ENTRIES = 4;

    localparam logic [1:0] IDX_ARM       = 2'd0;
    localparam logic [1:0] IDX_DRIVER    = 2'd1;
    localparam logic [1:0] IDX_PASSENGER = 2'd2;
    localparam logic [1:0] IDX_ALARM     = 2'd3;

    localparam time_t T_ARM_DEF       = 4'd6;
    localparam time_t T_DRIVER_DEF    = 4'd8;
    localparam time_t T_PASSENGER_DEF = 4'd15;
    localparam time_t T_ALARM_DEF     = 4'd10;

    function automatic logic siren_of(input state_t s);
        return (s == SOUND_ALARM) || (s == ALARM_HOLD);
    endfunction

    function automatic logic status_of(input state_t s, input logic blink);
        case (s)
            ARMED:                              return blink;
            TRIGGERED, SOUND_ALARM, ALARM_HOLD: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alarm_sequencer_time_param_regs.sv
// Four-entry delay table: one synchronous write port, one combinational
// read port. Entries reset to the supplied defaults.
module time_param_regs
    import alarm_pkg::*;
#(
    parameter time_t DEF_ARM       = T_ARM_DEF,
    parameter time_t DEF_DRIVER    = T_DRIVER_DEF,
    parameter time_t DEF_PASSENGER = T_PASSENGER_DEF,
    parameter time_t DEF_ALARM     = T_ALARM_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  time_t      wr_value,
    input  logic [1:0] rd_sel,
    output time_t      rd_value
);

    localparam logic [NUM_ENTRIES-1:0][3:0] DEFAULTS =
        {DEF_ALARM, DEF_PASSENGER, DEF_DRIVER, DEF_ARM};

    logic [NUM_ENTRIES-1:0][3:0] tbl;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                tbl[i] <= DEFAULTS[i];
            else if (wr_en && (wr_sel == 2'(i)))
                tbl[i] <= wr_value;
        end
    end

    assign rd_value = tbl[rd_sel];

endmodule

// File: rtl/alarm_sequencer.sv
// Anti-theft alarm control FSM: owns the delay table, starts the countdown
// timer and drives siren/status LED. `define FUEL_PUMP_EN adds the fuel-pump
// interlock (hidden_switch, brake, fuel_pump).
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter time_t T_ARM_DEFAULT       = T_ARM_DEF,
    parameter time_t T_DRIVER_DEFAULT    = T_DRIVER_DEF,
    parameter time_t T_PASSENGER_DEFAULT = T_PASSENGER_DEF,
    parameter time_t T_ALARM_DEFAULT     = T_ALARM_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    input  logic       half_hz_enable,
`ifdef FUEL_PUMP_EN
    input  logic       hidden_switch,
    input  logic       brake,
    output logic       fuel_pump,
`endif
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic       siren,
    output logic       status_indicator,
    output logic [2:0] state_out
);

    state_t     state, nxt;
    logic       start_req;
    logic [1:0] start_sel, sel_q;
    logic       blank_q;
    logic       expired_ok;
    logic       any_door;

    // The timer needs a cycle to load, so its expired level is stale during
    // the start pulse and the cycle after.
    assign expired_ok = expired && !start_timer && !blank_q;
    assign any_door   = door_driver || door_pass;

    time_param_regs #(
        .DEF_ARM       (T_ARM_DEFAULT),
        .DEF_DRIVER    (T_DRIVER_DEFAULT),
        .DEF_PASSENGER (T_PASSENGER_DEFAULT),
        .DEF_ALARM     (T_ALARM_DEFAULT)
    ) u_regs (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (reprogram),
        .wr_sel   (time_param_sel),
        .wr_value (time_value),
        .rd_sel   (sel_q),
        .rd_value (timer_value)
    );

    always_comb begin
        nxt       = state;
        start_req = 1'b0;
        start_sel = sel_q;
        if (reprogram) begin
            nxt = ARMED;
        end else if (ignition) begin
            nxt = DISARMED;
        end else begin
            case (state)
                DISARMED:
                    if (door_driver) nxt = WAIT_CLOSE;
                WAIT_CLOSE:
                    if (!any_door) begin
                        nxt       = ARM_DELAY;
                        start_req = 1'b1;
                        start_sel = IDX_ARM;
                    end
                ARM_DELAY:
                    if (any_door)        nxt = WAIT_CLOSE;
                    else if (expired_ok) nxt = ARMED;
                ARMED:
                    if (any_door) begin
                        nxt       = TRIGGERED;
                        start_req = 1'b1;
                        start_sel = door_driver ? IDX_DRIVER : IDX_PASSENGER;
                    end
                TRIGGERED:
                    if (expired_ok) nxt = SOUND_ALARM;
                SOUND_ALARM:
                    if (!any_door) begin
                        nxt       = ALARM_HOLD;
                        start_req = 1'b1;
                        start_sel = IDX_ALARM;
                    end
                ALARM_HOLD:
                    if (any_door)        nxt = SOUND_ALARM;
                    else if (expired_ok) nxt = ARMED;
                default:
                    nxt = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= DISARMED;
            start_timer      <= 1'b0;
            sel_q            <= IDX_ARM;
            blank_q          <= 1'b0;
            siren            <= 1'b0;
            status_indicator <= 1'b0;
        end else begin
            state            <= nxt;
            start_timer      <= start_req;
            blank_q          <= start_timer;
            siren            <= siren_of(nxt);
            status_indicator <= status_of(nxt, half_hz_enable);
            if (start_req)
                sel_q <= start_sel;
        end
    end

    assign state_out = state;

`ifdef FUEL_PUMP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fuel_pump <= 1'b0;
        else if (!ignition)
            fuel_pump <= 1'b0;
        else if (hidden_switch && brake)
            fuel_pump <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed-vector bench for alarm_sequencer; expected values hand-derived.
module tb_alarm_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ignition, door_driver, door_pass, reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired, half_hz_enable;
    logic       start_timer, siren, status_indicator;
    logic [3:0] timer_value;
    logic [2:0] state_out;
`ifdef FUEL_PUMP_EN
    logic       hidden_switch, brake, fuel_pump;
`endif

    int vectors     = 0;
    int miscompares = 0;

    alarm_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .ignition         (ignition),
        .door_driver      (door_driver),
        .door_pass        (door_pass),
        .reprogram        (reprogram),
        .time_param_sel   (time_param_sel),
        .time_value       (time_value),
        .expired          (expired),
        .half_hz_enable   (half_hz_enable),
`ifdef FUEL_PUMP_EN
        .hidden_switch    (hidden_switch),
        .brake            (brake),
        .fuel_pump        (fuel_pump),
`endif
        .start_timer      (start_timer),
        .timer_value      (timer_value),
        .siren            (siren),
        .status_indicator (status_indicator),
        .state_out        (state_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        ignition = 0; door_driver = 0; door_pass = 0; reprogram = 0;
        time_param_sel = 0; time_value = 0; expired = 0; half_hz_enable = 0;
`ifdef FUEL_PUMP_EN
        hidden_switch = 0; brake = 0;
`endif
        step(); step();
        check("rst_state",  state_out, 0);
        check("rst_start",  start_timer, 0);
        check("rst_siren",  siren, 0);
        check("rst_status", status_indicator, 0);
        reset = 1'b0;
        step();
        check("idle_state", state_out, 0);

        // Arm sequence with blanking of a level-high expired
        door_driver = 1; step();
        check("wait_close", state_out, 1);
        door_driver = 0; step();
        check("arm_delay", state_out, 2);
        check("arm_start", start_timer, 1);
        check("arm_value", timer_value, 6);
        expired = 1; step();
        check("blank1_state", state_out, 2);
        check("blank1_start", start_timer, 0);
        step();
        check("blank2_state", state_out, 2);
        step();
        check("armed", state_out, 3);
        expired = 0;
        half_hz_enable = 1; step();
        check("blink_hi", status_indicator, 1);
        half_hz_enable = 0; step();
        check("blink_lo", status_indicator, 0);

        // Both doors at once picks DRIVER; full alarm cycle
        door_driver = 1; door_pass = 1; step();
        check("trig_state", state_out, 4);
        check("trig_start", start_timer, 1);
        check("trig_driver_val", timer_value, 8);
        check("trig_status", status_indicator, 1);
        expired = 1; step(); step();
        check("trig_blank", state_out, 4);
        step();
        check("sound_state", state_out, 5);
        check("sound_siren", siren, 1);
        expired = 0; door_driver = 0; door_pass = 0; step();
        check("hold_state", state_out, 6);
        check("hold_start", start_timer, 1);
        check("hold_value", timer_value, 10);
        check("hold_siren", siren, 1);
        expired = 1; step(); step(); step();
        check("rearm_state", state_out, 3);
        check("rearm_siren", siren, 0);
        expired = 0;

        // Passenger-only trigger, then ignition beats expired
        door_pass = 1; step();
        check("trig_pass_state", state_out, 4);
        check("trig_pass_val", timer_value, 15);
        door_pass = 0; step(); step();
        ignition = 1; expired = 1; step();
        check("ign_state", state_out, 0);
        check("ign_siren", siren, 0);
        check("ign_status", status_indicator, 0);
        ignition = 0; expired = 0; step();

        // Door reopen during ARM_DELAY abandons countdown
        door_driver = 1; step();
        door_driver = 0; step();
        check("ad2_state", state_out, 2);
        door_pass = 1; expired = 1; step();
        check("reopen_state", state_out, 1);
        check("reopen_start", start_timer, 0);
        door_pass = 0; expired = 0; step();
        check("restart_state", state_out, 2);
        check("restart_start", start_timer, 1);
        check("restart_val", timer_value, 6);
        expired = 1; step(); step(); step();
        check("armed2", state_out, 3);
        expired = 0;
        door_driver = 1; step();
        expired = 1; step(); step(); step();
        check("sound2", state_out, 5);
        expired = 0;

        // Reprogram in SOUND_ALARM forces ARMED, no pulse
        reprogram = 1; time_param_sel = 1; time_value = 3; step();
        check("reprog_state", state_out, 3);
        check("reprog_siren", siren, 0);
        check("reprog_start", start_timer, 0);
        reprogram = 0; door_driver = 0; step();
        door_driver = 1; step();
        check("new_driver_val", timer_value, 3);
        check("new_driver_start", start_timer, 1);
        door_driver = 0;

        // Back-to-back writes to one index, last wins
        reprogram = 1; time_param_sel = 2; time_value = 9; step();
        time_value = 4; step();
        reprogram = 0; step();
        door_pass = 1; step();
        check("b2b_state", state_out, 4);
        check("b2b_val", timer_value, 4);

        // Zero ALARM delay: expiry acted on two cycles after start
        reprogram = 1; time_param_sel = 3; time_value = 0; door_pass = 0; step();
        reprogram = 0; door_pass = 1; step();
        expired = 1; step(); step(); step();
        check("sound3", state_out, 5);
        door_pass = 0; step();
        check("zero_val", timer_value, 0);
        check("zero_start", start_timer, 1);
        step();
        check("zero_blank", state_out, 6);
        step();
        check("zero_blank2", state_out, 6);
        step();
        check("zero_rearm", state_out, 3);
        expired = 0;

`ifdef FUEL_PUMP_EN
        ignition = 1; brake = 1; hidden_switch = 1; step();
        check("fuel_on", fuel_pump, 1);
        brake = 0; hidden_switch = 0; step();
        check("fuel_hold", fuel_pump, 1);
        ignition = 0; step();
        check("fuel_off", fuel_pump, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
